andor_arbiter: RTL and testbench
================================

Name: andor_arbiter

Overview:
- Shares one AND-OR evaluation unit, Y = (A & B) | (C & D), between N_REQ requesters on one clock.
- Each requester presents a 4-bit operand word and a request line. A round-robin arbiter grants one requester at a time, and a small FSM sequences the shared unit over a configurable number of cycles.
- The registered result is returned with a one-cycle valid strobe, tagged by the held one-hot grant.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- EVAL_CYCLES, 1, cycles the shared unit is occupied per operation (1..15).

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  N_REQ  per-requester request, level.
- OPS  input  4*N_REQ  operands; requester i owns bits [4i+3:4i] = {A,B,C,D}, with A at bit 4i+3.
- GNT  output  N_REQ  one-hot grant, held from the grant edge through the DONE cycle.
- Y_OUT  output  1  registered result of the granted operation.
- VALID  output  1  one-cycle strobe; Y_OUT is valid for the requester whose GNT bit is set.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low, RST_N.
- Reset values: state IDLE, GNT=0, Y_OUT=0, VALID=0, BUSY=0, round-robin pointer PTR=0, cycle counter=0, operand latch=0.
- Reset mid-operation: the operation is abandoned immediately, with no VALID and no pointer update.
- FSM states:
  - IDLE: if REQ != 0 at a rising edge, select the winner by scanning from index PTR upward with wrap-around. On that edge:
    - latch OPS[winner];
    - set GNT to one-hot(winner);
    - load counter = EVAL_CYCLES-1;
    - go to EVAL.
    If REQ == 0, stay in IDLE.
  - EVAL: the shared unit evaluates the latched operands. While counter != 0, decrement the counter. When counter == 0, register Y_OUT, set VALID=1, set PTR = (winner+1) mod N_REQ, and go to DONE.
  - DONE: lasts exactly one cycle, with VALID=1 and GNT held. At the next edge: VALID=0, GNT=0, go to IDLE.
- Latency: from the edge that samples REQ to the edge that raises VALID is EVAL_CYCLES+1 edges. With EVAL_CYCLES=1, VALID is high in the second cycle after the grant edge.
- Minimum throughput: one operation per EVAL_CYCLES+2 cycles.
- Handshake:
  - A requester holds REQ until it sees VALID together with its GNT bit, then drops REQ.
  - REQ still high in IDLE is treated as a new request.
  - Arbitration is never evaluated in EVAL or DONE. REQ changes there are ignored.
- Operand latching: operands are captured at the grant edge only. OPS changes after the grant do not affect the result.
- REQ withdrawn mid-operation: the operation completes and VALID still pulses. This is not an error.
- Simultaneous requests: strict round-robin from PTR. No requester waits more than N_REQ-1 operations.
- Single requester: the same requester is re-granted every operation, and PTR still advances past it.
- PTR wrap: winner N_REQ-1 sets PTR=0.
- Invariants:
  - GNT is zero or one-hot at all times.
  - VALID is never high for two consecutive cycles.
  - Y_OUT holds its value until the next DONE.

Decomposition:
- Shared package andor_arb_pkg:
  - state enum (IDLE, EVAL, DONE), 2-bit encoding;
  - OP_W = 4 operand width;
  - bit-position constants A_BIT=3, B_BIT=2, C_BIT=1, D_BIT=0.
- One sub-module, andor_eval: purely combinational Y from a 4-bit operand word, instantiated once as the shared resource.
- Round-robin selection stays inline in andor_arbiter as a function.

Test Plan:
- Single request, EVAL_CYCLES=1: reset, then REQ=0001 with OPS[3:0]=0111 -> GNT=0001 on the next edge, VALID=1 with Y_OUT=1 two cycles after the grant edge, BUSY high for 2 cycles.
- Zero result: OPS[3:0]=0010 via requester 0 -> Y_OUT=0 with VALID pulse. Then requester 2 with OPS[11:8]=1100 -> Y_OUT=1 and GNT=0100.
- Fairness: all REQ=1111 held continuously -> grants in order 0001, 0010, 0100, 1000, 0001. Each VALID is separated by 3 cycles. PTR wraps to 0 after requester 3.
- Multi-cycle and operand stability: EVAL_CYCLES=4, OPS changed on the cycle after the grant -> VALID arrives 5 edges after sampling, and Y_OUT reflects the latched operands, not the new ones.
- Withdrawal: requester drops REQ during EVAL -> VALID still pulses once, then state returns to IDLE and stays idle with REQ=0.
- Reset mid-operation: RST_N low during EVAL -> GNT, VALID, BUSY and Y_OUT go to 0 asynchronously. After release, REQ=0010 is granted first, since PTR was reset to 0 and requester 0 is idle.

Source files
------------

// File: rtl/andor_arb_pkg.sv
// Shared types and constants for the AND-OR arbiter slice.
// Contents: FSM state encoding, operand width, operand bit positions.
package andor_arb_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned A_BIT = 3;
    localparam int unsigned B_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned D_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : andor_arb_pkg

// File: rtl/andor_eval.sv
// Shared AND-OR evaluation unit: y = (A & B) | (C & D), purely combinational.
// Ports:
//   op_i  operand word {A,B,C,D}, A at the MSB
//   y_c   combinational result
module andor_eval
    import andor_arb_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output logic            y_c
);

    assign y_c = (op_i[A_BIT] & op_i[B_BIT]) | (op_i[C_BIT] & op_i[D_BIT]);

endmodule : andor_eval

// File: rtl/andor_arbiter.sv
// Round-robin arbiter sharing one AND-OR evaluation unit between N_REQ requesters.
// Ports:
//   CLK, RST_N  clock (rising edge), asynchronous active-low reset
//   REQ         per-requester request level
//   OPS         operands, requester i owns OPS[4i+3:4i] = {A,B,C,D}
//   GNT         one-hot grant, held from grant edge through the DONE cycle
//   Y_OUT       registered result of the granted operation
//   VALID       one-cycle strobe marking Y_OUT for the requester in GNT
//   BUSY        high whenever the FSM is not idle
module andor_arbiter
    import andor_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned EVAL_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [OP_W*N_REQ-1:0] OPS,
    output logic [N_REQ-1:0]      GNT,
    output logic                  Y_OUT,
    output logic                  VALID,
    output logic                  BUSY
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 4;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               y_q, y_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;

    logic [PTR_W-1:0]   win_c;
    logic [OP_W-1:0]    op_sel_c;
    logic               y_eval_c;

    // First requester at or after ptr, scanning upward with wrap-around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic        found;
        int unsigned idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && req[PTR_W'(idx)]) begin
                rr_pick = PTR_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    assign win_c = rr_pick(REQ, ptr_q);

    // Operand word of the current arbitration winner.
    always_comb begin
        op_sel_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_c == PTR_W'(i)) begin
                op_sel_c = OPS[i*OP_W +: OP_W];
            end
        end
    end

    andor_eval u_eval (
        .op_i (op_q),
        .y_c  (y_eval_c)
    );

    // Next-state and output decode; everything holds unless a transition says otherwise.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        y_d     = y_q;
        valid_d = 1'b0;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        op_d    = op_q;

        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    win_d   = win_c;
                    gnt_d   = N_REQ'(1) << win_c;
                    op_d    = op_sel_c;
                    cnt_d   = CNT_W'(EVAL_CYCLES - 1);
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    y_d     = y_eval_c;
                    valid_d = 1'b1;
                    ptr_d   = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign GNT   = gnt_q;
    assign Y_OUT = y_q;
    assign VALID = valid_q;
    assign BUSY  = busy_q;

endmodule : andor_arbiter

// File: tb/tb_andor_arbiter.sv
// Directed testbench for andor_arbiter: one instance with EVAL_CYCLES=1 and
// one with EVAL_CYCLES=4, sharing clock and reset.
module tb_andor_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req1, req4;
    logic [15:0] ops1, ops4;
    logic [3:0]  gnt1, gnt4;
    logic        y1, y4, valid1, valid4, busy1, busy4;

    int n_checks = 0;
    int n_fail   = 0;

    andor_arbiter #(.N_REQ(4), .EVAL_CYCLES(1)) dut1 (
        .CLK (clk), .RST_N (rst_n), .REQ (req1), .OPS (ops1),
        .GNT (gnt1), .Y_OUT (y1), .VALID (valid1), .BUSY (busy1)
    );

    andor_arbiter #(.N_REQ(4), .EVAL_CYCLES(4)) dut4 (
        .CLK (clk), .RST_N (rst_n), .REQ (req4), .OPS (ops4),
        .GNT (gnt4), .Y_OUT (y4), .VALID (valid4), .BUSY (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full status of the EVAL_CYCLES=1 instance in one call.
    task automatic check1(input string tag, input logic [3:0] g, input logic v,
                          input logic y, input logic b);
        check({tag, ".gnt"},   8'(gnt1),   8'(g));
        check({tag, ".valid"}, 8'(valid1), 8'(v));
        check({tag, ".y"},     8'(y1),     8'(y));
        check({tag, ".busy"},  8'(busy1),  8'(b));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_g;
    logic       exp_y;

    initial begin
        rst_n = 1'b0;
        req1  = '0; ops1 = '0;
        req4  = '0; ops4 = '0;

        // Reset values
        do_reset();
        check1("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        check("reset.gnt4", 8'(gnt4), 8'h0);

        // Single request, 0111 -> Y=1
        req1 = 4'b0001; ops1 = 16'h0007;
        tick();
        check1("single.grant", 4'b0001, 1'b0, 1'b0, 1'b1);
        tick();
        check1("single.valid", 4'b0001, 1'b1, 1'b1, 1'b1);
        req1 = '0;
        tick();
        check1("single.idle", 4'b0000, 1'b0, 1'b1, 1'b0);

        // Zero result via requester 0 (PTR=1, wraps back to 0)
        req1 = 4'b0001; ops1 = 16'h0002;
        tick();
        check1("zero.grant", 4'b0001, 1'b0, 1'b1, 1'b1);
        tick();
        check1("zero.valid", 4'b0001, 1'b1, 1'b0, 1'b1);
        req1 = '0;
        tick();

        // Requester 2 with 1100 -> Y=1
        req1 = 4'b0100; ops1 = 16'h0C00;
        tick();
        check1("r2.grant", 4'b0100, 1'b0, 1'b0, 1'b1);
        tick();
        check1("r2.valid", 4'b0100, 1'b1, 1'b1, 1'b1);
        req1 = '0;
        tick();
        check1("r2.idle", 4'b0000, 1'b0, 1'b1, 1'b0);

        // Fairness with all requests held: 0,1,2,3,0
        do_reset();
        req1 = 4'b1111; ops1 = 16'h8C07;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            case (k % 4)
                0:       exp_y = 1'b1;
                1:       exp_y = 1'b0;
                2:       exp_y = 1'b1;
                default: exp_y = 1'b0;
            endcase
            tick();
            check("fair.grant", 8'(gnt1), 8'(exp_g));
            check("fair.vlow", 8'(valid1), 8'h0);
            tick();
            check("fair.valid", 8'(valid1), 8'h1);
            check("fair.y", 8'(y1), 8'(exp_y));
            tick();
            check("fair.gap", 8'(valid1), 8'h0);
            check("fair.busy", 8'(busy1), 8'h0);
        end
        req1 = '0;
        tick();

        // Withdrawal during EVAL: PTR=1, requester 1 with 1111
        req1 = 4'b0010; ops1 = 16'h00F0;
        tick();
        check1("wd.grant", 4'b0010, 1'b0, 1'b1, 1'b1);
        req1 = '0;
        tick();
        check1("wd.valid", 4'b0010, 1'b1, 1'b1, 1'b1);
        tick();
        check1("wd.idle", 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        check1("wd.stay", 4'b0000, 1'b0, 1'b1, 1'b0);

        // Reset mid-operation (PTR=2 -> requester 2 granted, then abandoned)
        req1 = 4'b0100; ops1 = 16'h0C00;
        tick();
        check1("rmid.grant", 4'b0100, 1'b0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check1("rmid.async", 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        req1 = 4'b0110; ops1 = 16'h0CF0;
        tick();
        check1("rmid.regrant", 4'b0010, 1'b0, 1'b0, 1'b1);
        tick();
        check1("rmid.valid", 4'b0010, 1'b1, 1'b1, 1'b1);
        req1 = '0;
        tick();

        // Multi-cycle with operand change after grant: latched 0111 -> 1
        req4 = 4'b0001; ops4 = 16'h0007;
        tick();
        check("mc.grant", 8'(gnt4), 8'h1);
        ops4 = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mc.wait", 8'(valid4), 8'h0);
            check("mc.busy", 8'(busy4), 8'h1);
        end
        tick();
        check("mc.valid", 8'(valid4), 8'h1);
        check("mc.y", 8'(y4), 8'h1);
        check("mc.gnt", 8'(gnt4), 8'h1);
        req4 = '0;
        tick();
        check("mc.vdrop", 8'(valid4), 8'h0);
        check("mc.gdrop", 8'(gnt4), 8'h0);

        // Latched 1000 -> 0 even though operands become 1111
        req4 = 4'b0001; ops4 = 16'h0008;
        tick();
        ops4 = 16'h000F;
        tick(); tick(); tick(); tick();
        check("mc2.valid", 8'(valid4), 8'h1);
        check("mc2.y", 8'(y4), 8'h0);
        req4 = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_andor_arbiter
